// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: arbitrates the parking lot entrance and exit gates.
// Grants at most one gate per transaction and keeps the occupancy count. Entries
// are refused when the lot is full or the day is over. Every grant is followed by
// a guard interval of HOLD_CYCLES cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enter_req  entry sensor request (level, held until enter_ack)
//   exit_req   exit sensor request (level, held until exit_ack)
//   day_over   end of day; blocks new entries
//   enter_ack  one-cycle entrance grant / datapath enter strobe
//   exit_ack   one-cycle exit grant / datapath exit strobe
//   occupancy  cars currently parked
//   full       occupancy == CAPACITY
//   empty      occupancy == 0
//   busy       arbiter is not idle
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY    = 3,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_req,
  input  logic             exit_req,
  input  logic             day_over,
  output logic             enter_ack,
  output logic             exit_ack,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int unsigned       HOLD_W    = 4;
  localparam logic [CNT_W-1:0]  CAP_V     = CNT_W'(CAPACITY);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_enter;  // 1: entry served last, 0: exit served last
  logic [HOLD_W-1:0] hold_cnt;
  logic              enter_ok_c;
  logic              exit_ok_c;

  // Eligibility; only consulted while IDLE
  assign enter_ok_c = enter_req && (occupancy < CAP_V) && !day_over;
  assign exit_ok_c  = exit_req && (occupancy != '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a tie goes to the gate not served last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enter_ok_c && exit_ok_c) begin
          state_nxt = last_enter ? GRANT_OUT : GRANT_IN;
        end else if (enter_ok_c) begin
          state_nxt = GRANT_IN;
        end else if (exit_ok_c) begin
          state_nxt = GRANT_OUT;
        end
      end
      GRANT_IN:  state_nxt = HOLD;
      GRANT_OUT: state_nxt = HOLD;
      HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy, fairness flag and guard counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy  <= '0;
      last_enter <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      // Count moves on the edge entering the grant, so it lines up with the ack
      if (state == IDLE && state_nxt == GRANT_IN) begin
        occupancy <= occupancy + CNT_W'(1);
      end else if (state == IDLE && state_nxt == GRANT_OUT) begin
        occupancy <= occupancy - CNT_W'(1);
      end

      if (state == GRANT_IN) begin
        last_enter <= 1'b1;
      end else if (state == GRANT_OUT) begin
        last_enter <= 1'b0;
      end

      if (state != HOLD && state_nxt == HOLD) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    enter_ack = 1'b0;
    exit_ack  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:      busy      = 1'b0;
      GRANT_IN:  enter_ack = 1'b1;
      GRANT_OUT: exit_ack  = 1'b1;
      default:   busy      = 1'b1;
    endcase
  end

  assign full  = (occupancy == CAP_V);
  assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter with default parameters.
// Expected grants (gate, resulting occupancy) are queued when stimulus is driven
// and matched by a monitor whenever the DUT raises an ack.
module tb_parking_gate_arbiter;

  logic       clk;
  logic       reset;
  logic       enter_req;
  logic       exit_req;
  logic       day_over;
  logic       enter_ack;
  logic       exit_ack;
  logic [1:0] occupancy;
  logic       full;
  logic       empty;
  logic       busy;

  typedef struct {
    bit         is_enter;
    logic [1:0] occ;
  } exp_t;

  exp_t exp_q[$];
  int   ack_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  parking_gate_arbiter #(.CAPACITY(3), .CNT_W(2), .HOLD_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enter_req (enter_req),
    .exit_req  (exit_req),
    .day_over  (day_over),
    .enter_ack (enter_ack),
    .exit_ack  (exit_ack),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the oldest expected grant
  always @(negedge clk) begin
    if (reset) begin
      if (enter_ack && exit_ack) begin
        checks++;
        errors++;
        $display("FAIL both_acks: enter_ack=1 exit_ack=1 at cycle %0d, required at most one", cyc);
      end
      if (enter_ack || exit_ack) begin
        checks++;
        ack_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: enter_ack=%0b exit_ack=%0b occ=%0d at cycle %0d, required no ack",
                   enter_ack, exit_ack, occupancy, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (enter_ack !== e.is_enter || occupancy !== e.occ) begin
            errors++;
            $display("FAIL grant: got enter=%0b occ=%0d, required enter=%0b occ=%0d at cycle %0d",
                     enter_ack, occupancy, e.is_enter, e.occ, cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit is_enter, input logic [1:0] occ);
    exp_t e;
    e.is_enter = is_enter;
    e.occ      = occ;
    exp_q.push_back(e);
  endtask

  // Bounded wait for all queued grants to appear
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d grants outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    enter_req = 1'b0;
    exit_req  = 1'b0;
    day_over  = 1'b0;
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    ack_cycles.delete();
  endtask

  // One isolated grant, then let the arbiter return to IDLE
  task automatic one_grant(input bit is_enter, input logic [1:0] occ);
    push_exp(is_enter, occ);
    if (is_enter) enter_req = 1'b1;
    else          exit_req  = 1'b1;
    wait_drain("one_grant");
    enter_req = 1'b0;
    exit_req  = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    enter_req = 1'b0;
    exit_req  = 1'b0;
    day_over  = 1'b0;
    tick(3);
    checks++;
    if ({enter_ack, exit_ack, occupancy, full, empty, busy} !== 7'b00_00_0_1_0) begin
      errors++;
      $display("FAIL reset_state: ack=%0b%0b occ=%0d full=%0b empty=%0b busy=%0b, required 00 0 0 1 0",
               enter_ack, exit_ack, occupancy, full, empty, busy);
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b occ=%0d, required 0 0", busy, occupancy);
    end
  endtask

  task automatic test_single_entry();
    do_reset();
    push_exp(1'b1, 2'd1);
    enter_req = 1'b1;
    @(negedge clk);
    checks++;
    if (enter_ack !== 1'b1 || occupancy !== 2'd1 || empty !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: ack=%0b occ=%0d empty=%0b busy=%0b, required 1 1 0 1",
               enter_ack, occupancy, empty, busy);
    end
    enter_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (enter_ack !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold%0d: ack=%0b busy=%0b, required 0 1", i, enter_ack, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_idle: busy=%0b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_fill();
    int acks;
    do_reset();
    push_exp(1'b1, 2'd1);
    push_exp(1'b1, 2'd2);
    push_exp(1'b1, 2'd3);
    enter_req = 1'b1;
    wait_drain("fill");
    checks++;
    if (ack_cycles.size() != 3 || ack_cycles[1] - ack_cycles[0] != 4 || ack_cycles[2] - ack_cycles[1] != 4) begin
      errors++;
      $display("FAIL fill_spacing: %0d acks, gaps not 4 cycles, required 3 acks spaced 4", ack_cycles.size());
    end
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (enter_ack) acks++;
    end
    checks++;
    if (acks != 0 || full !== 1'b1 || occupancy !== 2'd3) begin
      errors++;
      $display("FAIL fill_full: extra_acks=%0d full=%0b occ=%0d, required 0 1 3", acks, full, occupancy);
    end
  endtask

  // Continues from a full lot with enter_req still held
  task automatic test_full_tie();
    push_exp(1'b0, 2'd2);
    push_exp(1'b1, 2'd3);
    push_exp(1'b0, 2'd2);
    exit_req = 1'b1;
    wait_drain("full_tie");
    enter_req = 1'b0;
    exit_req  = 1'b0;
    tick(4);
    checks++;
    if (occupancy !== 2'd2 || full !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_tie_end: occ=%0d full=%0b busy=%0b, required 2 0 0", occupancy, full, busy);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    one_grant(1'b1, 2'd1);
    one_grant(1'b1, 2'd2);
    one_grant(1'b0, 2'd1);
    push_exp(1'b1, 2'd2);
    push_exp(1'b0, 2'd1);
    push_exp(1'b1, 2'd2);
    enter_req = 1'b1;
    exit_req  = 1'b1;
    wait_drain("alternate");
    enter_req = 1'b0;
    exit_req  = 1'b0;
    tick(4);
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL alternate_occ: occ=%0d, required 2", occupancy);
    end
  endtask

  task automatic test_day_over();
    int acks;
    do_reset();
    one_grant(1'b1, 2'd1);
    one_grant(1'b1, 2'd2);
    day_over  = 1'b1;
    enter_req = 1'b1;
    tick(10);
    checks++;
    if (occupancy !== 2'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL day_over_block: occ=%0d busy=%0b, required 2 0", occupancy, busy);
    end
    push_exp(1'b0, 2'd1);
    push_exp(1'b0, 2'd0);
    exit_req = 1'b1;
    wait_drain("day_over_exit");
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (enter_ack || exit_ack) acks++;
    end
    checks++;
    if (acks != 0 || occupancy !== 2'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL day_over_empty: acks=%0d occ=%0d empty=%0b, required 0 0 1", acks, occupancy, empty);
    end
    enter_req = 1'b0;
    exit_req  = 1'b0;
    day_over  = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    one_grant(1'b1, 2'd1);
    one_grant(1'b1, 2'd2);
    push_exp(1'b1, 2'd3);
    enter_req = 1'b1;
    wait_drain("reset_mid_grant");
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: busy=%0b, required 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || busy !== 1'b0 || enter_ack !== 1'b0 || exit_ack !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: occ=%0d busy=%0b ack=%0b%0b empty=%0b, required 0 0 00 1",
               occupancy, busy, enter_ack, exit_ack, empty);
    end
    tick(2);
    push_exp(1'b1, 2'd1);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (enter_ack !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_regrant: ack=%0b occ=%0d, required 1 1", enter_ack, occupancy);
    end
    enter_req = 1'b0;
    wait_drain("reset_mid_regrant");
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_fill();
    test_full_tie();
    test_alternate();
    test_day_over();
    test_reset_mid();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
